uart_rx_frame_timer: RTL and testbench

- Parametrised successor to the UART RX edge/bit counter.
- Generates oversampling-edge and bit-position timing for one received frame.
- Runtime-selectable prescale (8/16/32), data length (5..8), optional parity and 1 or 2 stop bits.
- Sits between the RX FSM (which drives enable) and the data sampler/deserializer. Emits mid-bit sample strobes plus bit_done/frame_done pulses, so the FSM no longer decodes counter values itself.

---
 rtl/uart_rx_pkg.sv | 35 +++
 rtl/uart_rx_cfg_check.sv | 37 +++
 rtl/uart_rx_frame_timer.sv | 155 +++++++++++++++
 tb/tb_uart_rx_frame_timer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame timing logic.
//   - FSM state encodings (IDLE / COUNT / DONE)
//   - legal oversampling ratios and data-length limits
//   - configuration restored on reset
//   - mid-bit sample offsets, expressed as distances back from P/2
//   - frame_len(): total bit periods in a frame (start + data + parity + stop)
package uart_rx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam logic [3:0] DATA_LEN_MIN = 4'd5;
  localparam logic [3:0] DATA_LEN_MAX = 4'd8;

  localparam logic [5:0] RESET_PRESCALE = PRESCALE_16;
  localparam logic [3:0] RESET_DATA_LEN = 4'd8;

  // Sample k is taken at edge P/2 - SAMPLE_BACK_k (offsets -2, -1, 0).
  localparam logic [5:0] SAMPLE_BACK_0 = 6'd2;
  localparam logic [5:0] SAMPLE_BACK_1 = 6'd1;
  localparam logic [5:0] SAMPLE_BACK_2 = 6'd0;

  // Bit periods in one frame: start + data + optional parity + 1 or 2 stop.
  function automatic logic [3:0] frame_len(input logic [3:0] data_len,
                                           input logic       parity_en,
                                           input logic       stop_two);
    frame_len = 4'd1 + data_len + {3'b000, parity_en} + (stop_two ? 4'd2 : 4'd1);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_check.sv
// Combinational frame-configuration checker, shared by the RX and TX timers.
// Ports:
//   prescale  [5:0] in  oversampling ratio requested
//   data_len  [3:0] in  data bits per frame requested
//   parity_en       in  frame carries a parity bit
//   stop_two        in  frame carries two stop bits
//   legal           out configuration is supported
//   frame_n   [3:0] out bit periods per frame (valid when legal)
module uart_rx_cfg_check
  import uart_rx_pkg::*;
#(
  parameter int MAX_PRESCALE = 32
) (
  input  logic [5:0] prescale,
  input  logic [3:0] data_len,
  input  logic       parity_en,
  input  logic       stop_two,
  output logic       legal,
  output logic [3:0] frame_n
);

  logic prescale_ok_s;
  logic data_len_ok_s;

  // Validate ratio and data length; a ratio above the build limit is rejected.
  always_comb begin
    prescale_ok_s = 1'b0;
    case (prescale)
      PRESCALE_8, PRESCALE_16, PRESCALE_32: prescale_ok_s = (int'(prescale) <= MAX_PRESCALE);
      default:                              prescale_ok_s = 1'b0;
    endcase
    data_len_ok_s = (data_len >= DATA_LEN_MIN) && (data_len <= DATA_LEN_MAX);
    legal         = prescale_ok_s && data_len_ok_s;
    frame_n       = frame_len(data_len, parity_en, stop_two);
  end

endmodule

// File: rtl/uart_rx_frame_timer.sv
// Oversampling-edge and bit-position timer for one received UART frame.
// The RX FSM raises enable to start a frame; this block counts edges within
// each bit period and bit periods within the frame, and flags the three
// mid-bit sampling edges plus end-of-bit and end-of-frame.
// Ports:
//   CLK, RST         oversampling clock, asynchronous active-high reset
//   enable           frame in progress (low forces idle)
//   prescale, data_len, parity_en, stop_two   frame configuration, latched at start
//   edge_cnt, bit_cnt                         current edge / bit position
//   sample_stb, sample_idx                    mid-bit sample strobe and its index
//   bit_done, frame_done                      last edge of bit / of frame
//   cfg_err                                   start attempted with illegal config
module uart_rx_frame_timer
  import uart_rx_pkg::*;
#(
  parameter int MAX_PRESCALE = 32,
  parameter int EDGE_W       = $clog2(MAX_PRESCALE),
  parameter int BIT_W        = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic [5:0]        prescale,
  input  logic [3:0]        data_len,
  input  logic              parity_en,
  input  logic              stop_two,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic              sample_stb,
  output logic [1:0]        sample_idx,
  output logic              bit_done,
  output logic              frame_done,
  output logic              cfg_err
);

  logic              cfg_legal_s;
  logic [3:0]        cfg_frame_n_s;
  logic [1:0]        state_r;
  logic [EDGE_W-1:0] edge_cnt_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [5:0]        prescale_r;
  logic [BIT_W-1:0]  frame_len_r;
  logic              cfg_err_r;
  logic              counting_s;
  logic [5:0]        edge_ext_s;
  logic [5:0]        half_s;
  logic              last_edge_s;
  logic              last_bit_s;
  logic              sample_stb_s;
  logic [1:0]        sample_idx_s;

  uart_rx_cfg_check #(
    .MAX_PRESCALE(MAX_PRESCALE)
  ) u_cfg_check (
    .prescale (prescale),
    .data_len (data_len),
    .parity_en(parity_en),
    .stop_two (stop_two),
    .legal    (cfg_legal_s),
    .frame_n  (cfg_frame_n_s)
  );

  assign counting_s  = (state_r == ST_COUNT);
  assign edge_ext_s  = 6'(edge_cnt_r);
  assign half_s      = {1'b0, prescale_r[5:1]};
  assign last_edge_s = counting_s && (edge_ext_s == (prescale_r - 6'd1));
  assign last_bit_s  = (bit_cnt_r == (frame_len_r - BIT_W'(1'b1)));

  // Frame FSM and counters; config is captured only on the IDLE->COUNT step.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      edge_cnt_r  <= '0;
      bit_cnt_r   <= '0;
      prescale_r  <= RESET_PRESCALE;
      frame_len_r <= BIT_W'(frame_len(RESET_DATA_LEN, 1'b0, 1'b0));
      cfg_err_r   <= 1'b0;
    end else if (!enable) begin
      state_r    <= ST_IDLE;
      edge_cnt_r <= '0;
      bit_cnt_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cfg_legal_s) begin
            state_r     <= ST_COUNT;
            edge_cnt_r  <= '0;
            bit_cnt_r   <= '0;
            prescale_r  <= prescale;
            frame_len_r <= BIT_W'(cfg_frame_n_s);
            cfg_err_r   <= 1'b0;
          end else begin
            cfg_err_r <= 1'b1;
          end
        end
        ST_COUNT: begin
          if (last_edge_s) begin
            edge_cnt_r <= '0;
            if (last_bit_s) begin
              bit_cnt_r <= '0;
              state_r   <= ST_DONE;
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_W'(1'b1);
            end
          end else begin
            edge_cnt_r <= edge_cnt_r + EDGE_W'(1'b1);
          end
        end
        ST_DONE: begin
          // Hold until enable drops; no automatic restart.
          edge_cnt_r <= '0;
          bit_cnt_r  <= '0;
        end
        default: begin
          state_r    <= ST_IDLE;
          edge_cnt_r <= '0;
          bit_cnt_r  <= '0;
        end
      endcase
    end
  end

  // Decode the three mid-bit sampling edges from the registered edge count.
  always_comb begin
    sample_stb_s = 1'b0;
    sample_idx_s = 2'd0;
    if (counting_s) begin
      if (edge_ext_s == (half_s - SAMPLE_BACK_0)) begin
        sample_stb_s = 1'b1;
        sample_idx_s = 2'd0;
      end else if (edge_ext_s == (half_s - SAMPLE_BACK_1)) begin
        sample_stb_s = 1'b1;
        sample_idx_s = 2'd1;
      end else if (edge_ext_s == (half_s - SAMPLE_BACK_2)) begin
        sample_stb_s = 1'b1;
        sample_idx_s = 2'd2;
      end else begin
        sample_stb_s = 1'b0;
        sample_idx_s = 2'd0;
      end
    end else begin
      sample_stb_s = 1'b0;
      sample_idx_s = 2'd0;
    end
  end

  assign edge_cnt   = edge_cnt_r;
  assign bit_cnt    = bit_cnt_r;
  assign sample_stb = sample_stb_s;
  assign sample_idx = sample_idx_s;
  assign bit_done   = last_edge_s;
  assign frame_done = last_edge_s && last_bit_s;
  assign cfg_err    = cfg_err_r;

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Self-checking bench for uart_rx_frame_timer: table of frame configurations
// run through a cycle-level reference model, plus hand-written sequences for
// mid-frame config change, abort, asynchronous reset and reset-vs-enable.
module tb_uart_rx_frame_timer;

  logic       CLK;
  logic       RST;
  logic       enable;
  logic [5:0] prescale;
  logic [3:0] data_len;
  logic       parity_en;
  logic       stop_two;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sample_stb;
  logic [1:0] sample_idx;
  logic       bit_done;
  logic       frame_done;
  logic       cfg_err;

  uart_rx_frame_timer dut (
    .CLK(CLK), .RST(RST), .enable(enable), .prescale(prescale),
    .data_len(data_len), .parity_en(parity_en), .stop_two(stop_two),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .sample_stb(sample_stb),
    .sample_idx(sample_idx), .bit_done(bit_done), .frame_done(frame_done),
    .cfg_err(cfg_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0] prescale;
    logic [3:0] data_len;
    logic       parity_en;
    logic       stop_two;
    logic       legal;
    int         exp_n;
  } vec_t;

  typedef struct {
    int   ecnt;
    int   bcnt;
    logic stb;
    int   idx;
    logic bd;
    logic fd;
    logic err;
  } exp_t;

  vec_t vecs[8];
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int m_state, m_k, m_p, m_n;
  logic m_err;
  int cyc_cnt, fd_seen, bd_seen, fd_cycle;

  // Reference: position in frame is a single count k of edges since start.
  function automatic logic model_legal();
    return (prescale == 6'd8 || prescale == 6'd16 || prescale == 6'd32) &&
           (data_len >= 4'd5) && (data_len <= 4'd8);
  endfunction

  task automatic model_step(input logic en);
    if (RST) begin
      m_state = 0; m_k = 0; m_p = 16; m_n = 10; m_err = 1'b0;
    end else if (!en) begin
      m_state = 0; m_k = 0;
    end else if (m_state == 0) begin
      if (model_legal()) begin
        m_state = 1; m_k = 0; m_p = int'(prescale);
        m_n = 1 + int'(data_len) + int'(parity_en) + (stop_two ? 2 : 1);
        m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else if (m_state == 1) begin
      if (m_k == m_p * m_n - 1) begin m_state = 2; m_k = 0; end
      else m_k = m_k + 1;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int ed;
    e = '{0, 0, 1'b0, 0, 1'b0, 1'b0, m_err};
    if (m_state == 1) begin
      ed = m_k % m_p;
      e.ecnt = ed;
      e.bcnt = m_k / m_p;
      e.stb  = (ed >= m_p / 2 - 2) && (ed <= m_p / 2);
      e.idx  = e.stb ? ed - (m_p / 2 - 2) : 0;
      e.bd   = (ed == m_p - 1);
      e.fd   = (m_k == m_p * m_n - 1);
    end
    return e;
  endfunction

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, req);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    e = exp_q.pop_front();
    checks++;
    if (int'(edge_cnt) != e.ecnt || int'(bit_cnt) != e.bcnt || sample_stb != e.stb ||
        int'(sample_idx) != e.idx || bit_done != e.bd || frame_done != e.fd ||
        cfg_err != e.err) begin
      failures++;
      $display("FAIL cycle %0d: got e=%0d b=%0d stb=%0b idx=%0d bd=%0b fd=%0b err=%0b expected e=%0d b=%0d stb=%0b idx=%0d bd=%0b fd=%0b err=%0b",
               cyc_cnt, edge_cnt, bit_cnt, sample_stb, sample_idx, bit_done, frame_done, cfg_err,
               e.ecnt, e.bcnt, e.stb, e.idx, e.bd, e.fd, e.err);
    end
    if (frame_done) begin fd_seen++; fd_cycle = cyc_cnt; end
    if (bit_done) bd_seen++;
  endtask

  // One clock: drive at negedge, push expectation, compare at next negedge.
  task automatic cycle(input logic en);
    enable = en;
    cyc_cnt++;
    model_step(en);
    exp_q.push_back(model_out());
    @(posedge CLK);
    @(negedge CLK);
    compare_out();
  endtask

  task automatic set_cfg(input logic [5:0] p, input logic [3:0] d, input logic pe, input logic s2);
    prescale = p; data_len = d; parity_en = pe; stop_two = s2;
  endtask

  task automatic clear_stats();
    cyc_cnt = 0; fd_seen = 0; bd_seen = 0; fd_cycle = -1;
  endtask

  initial begin
    vecs[0] = '{6'd16, 4'd8, 1'b0, 1'b0, 1'b1, 10};
    vecs[1] = '{6'd8,  4'd5, 1'b1, 1'b1, 1'b1, 9};
    vecs[2] = '{6'd32, 4'd7, 1'b1, 1'b1, 1'b1, 11};
    vecs[3] = '{6'd12, 4'd8, 1'b0, 1'b0, 1'b0, 0};
    vecs[4] = '{6'd16, 4'd9, 1'b0, 1'b0, 1'b0, 0};
    vecs[5] = '{6'd16, 4'd5, 1'b0, 1'b0, 1'b1, 7};
    vecs[6] = '{6'd8,  4'd4, 1'b0, 1'b0, 1'b0, 0};
    vecs[7] = '{6'd32, 4'd8, 1'b1, 1'b1, 1'b1, 12};

    RST = 1'b1; enable = 1'b0;
    set_cfg(6'd16, 4'd8, 1'b0, 1'b0);
    model_step(1'b0);
    clear_stats();
    @(negedge CLK); @(negedge CLK);
    check_int("reset edge_cnt", int'(edge_cnt), 0);
    check_int("reset bit_cnt", int'(bit_cnt), 0);
    check_int("reset pulses", int'({sample_stb, bit_done, frame_done, cfg_err}), 0);
    RST = 1'b0;

    // Table-driven frames; each legal one is held in DONE for 4 extra cycles.
    for (int i = 0; i < 8; i++) begin
      int run;
      set_cfg(vecs[i].prescale, vecs[i].data_len, vecs[i].parity_en, vecs[i].stop_two);
      cycle(1'b0);
      clear_stats();
      run = vecs[i].legal ? int'(vecs[i].prescale) * vecs[i].exp_n + 4 : 4;
      for (int c = 0; c < run; c++) cycle(1'b1);
      check_int("frame_done count", fd_seen, vecs[i].legal ? 1 : 0);
      check_int("cfg_err after start", int'(cfg_err), vecs[i].legal ? 0 : 1);
      if (vecs[i].legal) begin
        check_int("frame_done cycle", fd_cycle, int'(vecs[i].prescale) * vecs[i].exp_n);
        check_int("bit_done count", bd_seen, vecs[i].exp_n);
      end
      cycle(1'b0);
    end

    // Mid-frame config change at bit 3 must not alter timing.
    set_cfg(6'd16, 4'd8, 1'b0, 1'b0);
    cycle(1'b0);
    clear_stats();
    for (int c = 0; c < 50; c++) cycle(1'b1);
    set_cfg(6'd8, 4'd5, 1'b1, 1'b1);
    for (int c = 0; c < 115; c++) cycle(1'b1);
    check_int("midchange frame_done cycle", fd_cycle, 160);
    check_int("midchange bit_done count", bd_seen, 10);

    // Abort at bit 4, edge 5.
    set_cfg(6'd16, 4'd8, 1'b0, 1'b0);
    cycle(1'b0);
    clear_stats();
    for (int c = 0; c < 70; c++) cycle(1'b1);
    check_int("abort edge_cnt", int'(edge_cnt), 5);
    check_int("abort bit_cnt", int'(bit_cnt), 4);
    for (int c = 0; c < 5; c++) cycle(1'b0);
    check_int("abort frame_done count", fd_seen, 0);

    // Asynchronous reset mid-frame clears outputs before the next edge.
    clear_stats();
    for (int c = 0; c < 30; c++) cycle(1'b1);
    RST = 1'b1;
    #1;
    check_int("async rst edge_cnt", int'(edge_cnt), 0);
    check_int("async rst bit_cnt", int'(bit_cnt), 0);
    cycle(1'b1);  // reset held while enable high: reset wins
    RST = 1'b0;
    cycle(1'b0);

    // Reset also clears a held cfg_err asynchronously.
    set_cfg(6'd12, 4'd8, 1'b0, 1'b0);
    cycle(1'b1);
    cycle(1'b1);
    check_int("cfg_err set", int'(cfg_err), 1);
    RST = 1'b1;
    #1;
    check_int("async rst cfg_err", int'(cfg_err), 0);
    cycle(1'b0);
    RST = 1'b0;
    cycle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
